// File: rtl/div_pkg.sv
// Shared definitions for the iterative non-restoring divider.
//   DIV_W             operand / quotient / remainder width
//   DIV_CNT_W         iteration counter width (2**DIV_CNT_W > DIV_W)
//   DIV_QUOT_ALL_ONES quotient reported for a zero divisor
//   div_state_t       controller states
package div_pkg;

  localparam int unsigned DIV_W     = 11;
  localparam int unsigned DIV_CNT_W = 4;

  localparam logic [DIV_W-1:0] DIV_QUOT_ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/nr_addsub_step.sv
// One add/subtract step of the non-restoring divider.
//   p      in   W+1  partial remainder operand (two's complement)
//   d      in   W+1  divisor, zero-extended
//   sub    in   1    1 = p - d, 0 = p + d
//   sum    out  W+1  result, modulo 2**(W+1)
//   q_bit  out  1    quotient bit, the inverted sign of sum
module nr_addsub_step #(
  parameter int unsigned W = 11
) (
  input  logic [W:0] p,
  input  logic [W:0] d,
  input  logic       sub,
  output logic [W:0] sum,
  output logic       q_bit
);

  always_comb begin
    sum   = sub ? (p - d) : (p + d);
    q_bit = ~sum[W];
  end

endmodule

// File: rtl/seq_nr_divider11.sv
// Iterative radix-2 non-restoring unsigned divider, one quotient bit per clock.
//   clock        in   1  rising-edge clock
//   reset_n      in   1  asynchronous active-low reset
//   start        in   1  request, sampled only while idle
//   dividend     in   W  numerator, captured on the accepting edge
//   divisor      in   W  denominator, captured on the accepting edge
//   busy         out  1  iterating or correcting
//   done         out  1  one-cycle pulse, results valid
//   quotient     out  W  result, held until the next accepted start
//   remainder    out  W  result, held until the next accepted start
//   div_by_zero  out  1  divisor was zero; held like quotient
module seq_nr_divider11
  import div_pkg::*;
#(
  parameter int unsigned W     = DIV_W,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  div_state_t       state, next_state;
  logic [W:0]       p_r;
  logic [W-1:0]     q_r;
  logic [W-1:0]     d_r;
  logic [CNT_W-1:0] count;

  logic [W:0]       as_p;
  logic [W:0]       as_d;
  logic             as_sub;
  logic [W:0]       as_sum;
  logic             as_qbit;

  // The single add/sub unit serves both the RUN iteration (on the shifted
  // partial remainder) and the FIX correction (on the unshifted one).
  always_comb begin
    as_d = {1'b0, d_r};
    if (state == S_FIX) begin
      as_p   = p_r;
      as_sub = 1'b0;
    end else begin
      as_p   = {p_r[W-1:0], q_r[W-1]};
      as_sub = ~p_r[W];
    end
  end

  nr_addsub_step #(.W(W)) u_step (
    .p     (as_p),
    .d     (as_d),
    .sub   (as_sub),
    .sum   (as_sum),
    .q_bit (as_qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (divisor != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == CNT_W'(W - 1)) next_state = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              p_r   <= '0;
              q_r   <= dividend;
              d_r   <= divisor;
              count <= '0;
            end else begin
              quotient    <= DIV_QUOT_ALL_ONES;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          p_r   <= as_sum;
          q_r   <= {q_r[W-2:0], as_qbit};
          count <= count + CNT_W'(1);
        end
        S_FIX: begin
          quotient    <= q_r;
          remainder   <= p_r[W] ? as_sum[W-1:0] : p_r[W-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nr_divider11.sv
module tb_seq_nr_divider11;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [10:0] dividend;
  logic [10:0] divisor;
  logic        busy;
  logic        done;
  logic [10:0] quotient;
  logic [10:0] remainder;
  logic        div_by_zero;

  int tests  = 0;
  int errors = 0;

  seq_nr_divider11 dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain integer division; zero divisor gives all-ones, dividend.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int lat);
    if (b == 0) begin
      q = 2047; r = a; dz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = 13;
    end
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(negedge clock);
    while ((busy || done) && guard < 50) begin
      @(negedge clock);
      guard++;
    end
  endtask

  // Drives one request; edges counts the accepting edge as 1 up to the edge
  // after which done is seen; bcnt counts busy cycles before done.
  task automatic run_op(input int a, input int b, output int edges, output int bcnt,
                        output logic got);
    wait_idle();
    dividend = 11'(a);
    divisor  = 11'(b);
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 1;
    bcnt  = 0;
    while (!done && edges < 40) begin
      if (busy) bcnt++;
      @(posedge clock); #1;
      edges++;
    end
    got = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 25'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h expected 0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      tests++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 25'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: outputs=%h expected 0", i,
                 {busy, done, quotient, remainder, div_by_zero});
      end
    end
  endtask

  task automatic test_basic();
    int e, bc; logic g;
    run_op(100, 7, e, bc, g);
    tests++;
    if (!g || quotient !== 11'd14 || remainder !== 11'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_100_7: done=%0b q=%0d r=%0d dz=%0b expected done=1 q=14 r=2 dz=0",
               g, quotient, remainder, div_by_zero);
    end
    tests++;
    if (e !== 13) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d expected 13", e);
    end
    tests++;
    if (bc !== 12) begin
      errors++;
      $display("FAIL basic_busy: busy cycles=%0d expected 12", bc);
    end
  endtask

  task automatic test_corners();
    int ta[4] = '{2047, 5, 2047, 1024};
    int tb[4] = '{1, 9, 2047, 3};
    int tq[4] = '{2047, 0, 1, 341};
    int tr[4] = '{0, 5, 0, 1};
    int e, bc; logic g;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], e, bc, g);
      tests++;
      if (!g || quotient !== 11'(tq[i]) || remainder !== 11'(tr[i]) || div_by_zero !== 1'b0 || e !== 13) begin
        errors++;
        $display("FAIL corner %0d/%0d: done=%0b q=%0d r=%0d dz=%0b edges=%0d expected q=%0d r=%0d dz=0 edges=13",
                 ta[i], tb[i], g, quotient, remainder, div_by_zero, e, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int e, bc; logic g;
    run_op(37, 0, e, bc, g);
    tests++;
    if (!g || e !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL dz_latency: done=%0b edges=%0d busy=%0d expected done=1 edges=1 busy=0", g, e, bc);
    end
    tests++;
    if (quotient !== 11'd2047 || remainder !== 11'd37 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: q=%0d r=%0d dz=%0b expected q=2047 r=37 dz=1",
               quotient, remainder, div_by_zero);
    end
    run_op(8, 2, e, bc, g);
    tests++;
    if (!g || quotient !== 11'd4 || remainder !== 11'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_followup_8_2: q=%0d r=%0d dz=%0b expected q=4 r=0 dz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int e;
    logic [10:0] hq, hr;
    logic        hd;
    wait_idle();
    dividend = 11'd100; divisor = 11'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; e = 1;
    repeat (5) begin @(posedge clock); #1; e++; end
    dividend = 11'd500; divisor = 11'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; e++;
    dividend = '0; divisor = '0;
    while (!done && e < 40) begin @(posedge clock); #1; e++; end
    tests++;
    if (!done || e !== 13 || quotient !== 11'd14 || remainder !== 11'd2) begin
      errors++;
      $display("FAIL ignore_start: done=%0b edges=%0d q=%0d r=%0d expected done=1 edges=13 q=14 r=2",
               done, e, quotient, remainder);
    end
    hq = 11'd14; hr = 11'd2; hd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      tests++;
      if (quotient !== hq || remainder !== hr || div_by_zero !== hd || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: q=%0d r=%0d dz=%0b done=%0b busy=%0b expected q=14 r=2 dz=0 done=0 busy=0",
                 i, quotient, remainder, div_by_zero, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, bc; logic g; int seen;
    wait_idle();
    dividend = 11'd1000; divisor = 11'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h expected 0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (16) begin @(posedge clock); #1; if (done) seen++; end
    tests++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done pulses=%0d expected 0", seen);
    end
    run_op(9, 4, e, bc, g);
    tests++;
    if (!g || quotient !== 11'd2 || remainder !== 11'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_9_4: q=%0d r=%0d expected q=2 r=1", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    wait_idle();
    dividend = 11'd200; divisor = 11'd9; start = 1'b1;
    @(posedge clock); #1;
    e = 1;
    while (!done && e < 40) begin @(posedge clock); #1; e++; end
    tests++;
    if (!done || e !== 13 || quotient !== 11'd22 || remainder !== 11'd2) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d q=%0d r=%0d expected edges=13 q=22 r=2", e, quotient, remainder);
    end
    dividend = 11'd300; divisor = 11'd7;
    e = 0;
    do begin @(posedge clock); #1; e++; end while (!done && e < 40);
    start = 1'b0;
    tests++;
    if (!done || e !== 14 || quotient !== 11'd42 || remainder !== 11'd6) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d q=%0d r=%0d expected edges=14 q=42 r=6", e, quotient, remainder);
    end
  endtask

  task automatic test_random();
    int a, b, eq, er, edz, elat, e, bc; logic g;
    for (int n = 0; n < 3000; n++) begin
      a = int'($urandom_range(0, 2047));
      case ($urandom_range(0, 15))
        0:       b = 0;
        1, 2, 3: b = int'($urandom_range(1, 15));
        default: b = int'($urandom_range(1, 2047));
      endcase
      model(a, b, eq, er, edz, elat);
      run_op(a, b, e, bc, g);
      tests++;
      if (!g || quotient !== 11'(eq) || remainder !== 11'(er) || div_by_zero !== 1'(edz) || e !== elat) begin
        errors++;
        $display("FAIL random %0d/%0d: done=%0b q=%0d r=%0d dz=%0b edges=%0d expected q=%0d r=%0d dz=%0d edges=%0d",
                 a, b, g, quotient, remainder, div_by_zero, e, eq, er, edz, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
